// File: rtl/part1_ctrl.sv
// rtl/part1_ctrl.sv - series-term sequencer FSM for the part_1 datapath
// Moore-decoded control pins are registered from the next state; counter_en is the only live decode.
module part1_ctrl #(
  parameter int LAST_IDX = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       term_ack,
  input  logic       co_in,
  input  logic [2:0] count_in,
  output logic       ldx,
  output logic       ldt,
  output logic       init_t,
  output logic       init_counter,
  output logic       counter_en,
  output logic       select,
  output logic       term_valid,
  output logic [2:0] term_idx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MUL_X,
    S_MUL_C,
    S_EMIT,
    S_DONE
  } state_e;

  localparam logic [2:0] LAST_3 = 3'(LAST_IDX);

  state_e     state_q;
  state_e     state_d;
  logic [7:0] out_q;
  logic       last;

  // The full-width case relies on the datapath's carry-out rather than a compare.
  assign last = (LAST_IDX == 7) ? co_in : (count_in == LAST_3);

  // {ldx, ldt, init_t, init_counter, select, term_valid, busy, done}
  function automatic logic [7:0] decode(input state_e s);
    case (s)
      S_LOAD:  decode = 8'b1011_0010;
      S_MUL_X: decode = 8'b0100_0010;
      S_MUL_C: decode = 8'b0100_1010;
      S_EMIT:  decode = 8'b0000_0110;
      S_DONE:  decode = 8'b0000_0011;
      default: decode = 8'b0000_0000;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    if (state_q != S_IDLE && abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = S_LOAD;
        S_LOAD:  state_d = S_MUL_X;
        S_MUL_X: state_d = S_MUL_C;
        S_MUL_C: state_d = S_EMIT;
        S_EMIT:  if (term_ack) state_d = last ? S_DONE : S_MUL_X;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= decode(state_d);
    end
  end

  assign {ldx, ldt, init_t, init_counter, select, term_valid, busy, done} = out_q;

  // Advance only on an accepted, non-final term that is not being aborted or reset away.
  assign counter_en = term_valid && term_ack && !last && !abort && rst;
  assign term_idx   = count_in;

endmodule

// File: tb/tb_part1_ctrl.sv
// tb/tb_part1_ctrl.sv - randomized and directed bench for part1_ctrl with a schedule-based reference model
module tb_part1_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0, start = 1'b0, abort = 1'b0, ack = 1'b1;
  logic [15:0] xbus = 16'h8000;
  logic [1:0]  co_w, ldx_w, ldt_w, it_w, ic_w, ce_w, sel_w, tv_w, busy_w, done_w;
  logic [2:0]  cnt_w [2];
  logic [2:0]  idx_w [2];

  part1_ctrl #(.LAST_IDX(7)) u7 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .term_ack(ack),
    .co_in(co_w[0]), .count_in(cnt_w[0]), .ldx(ldx_w[0]), .ldt(ldt_w[0]),
    .init_t(it_w[0]), .init_counter(ic_w[0]), .counter_en(ce_w[0]),
    .select(sel_w[0]), .term_valid(tv_w[0]), .term_idx(idx_w[0]),
    .busy(busy_w[0]), .done(done_w[0])
  );

  part1_ctrl #(.LAST_IDX(3)) u3 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .term_ack(ack),
    .co_in(co_w[1]), .count_in(cnt_w[1]), .ldx(ldx_w[1]), .ldt(ldt_w[1]),
    .init_t(it_w[1]), .init_counter(ic_w[1]), .counter_en(ce_w[1]),
    .select(sel_w[1]), .term_valid(tv_w[1]), .term_idx(idx_w[1]),
    .busy(busy_w[1]), .done(done_w[1])
  );

  function automatic logic [15:0] coef(input int j);
    case (j)
      0: coef = 16'hFFFF;
      1: coef = 16'h8000;
      2: coef = 16'h5555;
      3: coef = 16'h4000;
      4: coef = 16'h3333;
      5: coef = 16'h2AAA;
      6: coef = 16'h2492;
      default: coef = 16'h2000;
    endcase
  endfunction

  function automatic logic [15:0] mulhi(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    mulhi = p[31:16];
  endfunction

  function automatic logic [15:0] exp_term(input logic [15:0] x, input int k);
    logic [15:0] t;
    t = 16'hFFFF;
    for (int j = 0; j <= k; j++) begin
      t = mulhi(t, x);
      t = mulhi(t, coef(j));
    end
    exp_term = t;
  endfunction

  // part_1 datapath stand-in, driven by the controller pins
  logic [15:0] dp_x [2] = '{16'h0, 16'h0};
  logic [15:0] dp_t [2] = '{16'h0, 16'h0};
  logic [2:0]  dp_c [2] = '{3'd0, 3'd0};
  assign cnt_w[0] = dp_c[0];
  assign cnt_w[1] = dp_c[1];
  assign co_w[0]  = (dp_c[0] == 3'd7);
  assign co_w[1]  = (dp_c[1] == 3'd7);

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ldx_w[i]) dp_x[i] <= xbus;
      if (it_w[i]) dp_t[i] <= 16'hFFFF;
      else if (ldt_w[i]) dp_t[i] <= mulhi(sel_w[i] ? coef(int'(dp_c[i])) : dp_x[i], dp_t[i]);
      if (ic_w[i]) dp_c[i] <= 3'd0;
      else if (ce_w[i]) dp_c[i] <= dp_c[i] + 3'd1;
    end
  end

  // Reference: a series is a position count since start; pos 1 is the load, then 3 cycles per term
  int          cyc = 0;
  int          m_act [2] = '{0, 0};
  int          m_pos [2] = '{0, 0};
  int          m_done [2] = '{0, 0};
  int          sc [2] = '{0, 0};
  int          done_rel [2] = '{-1, -1};
  logic [15:0] m_x [2];
  int          last_k [2] = '{7, 3};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        m_act[i] = 0; m_done[i] = 0;
      end else if (m_done[i] != 0) begin
        m_done[i] = 0;
      end else if (m_act[i] == 0) begin
        if (start) begin m_act[i] = 1; m_pos[i] = 1; sc[i] = cyc; end
      end else if (abort) begin
        m_act[i] = 0;
      end else if (m_pos[i] >= 2 && (m_pos[i] - 2) % 3 == 2) begin
        if (ack) begin
          if ((m_pos[i] - 2) / 3 == last_k[i]) begin m_act[i] = 0; m_done[i] = 1; end
          else m_pos[i]++;
        end
      end else begin
        if (m_pos[i] == 1) m_x[i] = xbus;
        m_pos[i]++;
      end
    end
    cyc++;
  end

  int n_pass = 0, n_tot = 0;
  bit run = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic compare(input int i);
    logic [8:0] got, exp;
    int r, k;
    bit tv;
    exp = '0; tv = 0; k = 0;
    if (m_done[i] != 0) exp = 9'b0_0000_0011;
    else if (m_act[i] != 0) begin
      if (m_pos[i] == 1) exp = 9'b1_0110_0010;
      else begin
        r = (m_pos[i] - 2) % 3;
        k = (m_pos[i] - 2) / 3;
        if (r == 0) exp = 9'b0_1000_0010;
        else if (r == 1) exp = 9'b0_1000_1010;
        else begin
          tv = 1;
          exp = {4'b0000, ack && (k != last_k[i]) && !abort && rst, 4'b0110};
        end
      end
    end
    got = {ldx_w[i], ldt_w[i], it_w[i], ic_w[i], ce_w[i], sel_w[i], tv_w[i], busy_w[i], done_w[i]};
    chk($sformatf("u%0d_ctl", i), 32'(got), 32'(exp));
    if (tv) begin
      chk($sformatf("u%0d_idx", i), 32'(idx_w[i]), 32'(k));
      chk($sformatf("u%0d_term%0d", i, k), 32'(dp_t[i]), 32'(exp_term(m_x[i], k)));
    end
    if (done_w[i]) done_rel[i] = cyc - sc[i];
  endtask

  always @(negedge clk) if (run) for (int i = 0; i < 2; i++) compare(i);

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy_w != 2'b00) && n < 200) begin next_cycle(); n++; end
    if (n >= 200) chk({name, "_timeout"}, 32'(busy_w), 32'd0);
  endtask

  task automatic wait_tv(input string name);
    int n;
    n = 0;
    while (!tv_w[0] && n < 60) begin next_cycle(); n++; end
    if (n >= 60) chk({name, "_timeout"}, 32'(tv_w[0]), 32'd1);
  endtask

  task automatic kick();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
  endtask

  int idle_n [2];
  int done_n [2];

  initial begin
    // held reset ignores start
    rst = 1'b0; start = 1'b1;
    next_cycle();
    run = 1'b1;
    repeat (3) next_cycle();
    chk("rst_hold_busy", 32'(busy_w), 32'd0);
    start = 1'b0; rst = 1'b1;
    next_cycle();

    // nominal series, ack tied high
    done_rel = '{-1, -1};
    xbus = 16'h8000;
    kick();
    wait_tv("t0");
    chk("t0_cycle", 32'(cyc - sc[0]), 32'd4);
    chk("t0_value", 32'(dp_t[0]), 32'h7FFE);
    next_cycle();
    wait_tv("t1");
    chk("t1_cycle", 32'(cyc - sc[0]), 32'd7);
    chk("t1_value", 32'(dp_t[0]), 32'h1FFF);
    wait_idle("nominal");
    chk("done7_cycle", 32'(done_rel[0]), 32'd26);
    chk("done3_cycle", 32'(done_rel[1]), 32'd14);

    // five-cycle ack stall on term 3
    done_rel = '{-1, -1};
    kick();
    while (cyc - sc[0] < 13) next_cycle();
    ack = 1'b0;
    repeat (5) next_cycle();
    ack = 1'b1;
    chk("stall_hold", {28'd0, tv_w[0], idx_w[0]}, 32'h0000_000B);
    wait_idle("stall");
    chk("stall_done7", 32'(done_rel[0]), 32'd31);
    chk("stall_done3", 32'(done_rel[1]), 32'd19);

    // start held: one series per idle visit
    idle_n = '{0, 0}; done_n = '{0, 0};
    start = 1'b1;
    for (int r = 1; r <= 60; r++) begin
      next_cycle();
      for (int i = 0; i < 2; i++) begin
        if (!busy_w[i]) idle_n[i]++;
        if (done_w[i]) done_n[i]++;
      end
    end
    start = 1'b0;
    chk("held_idle7", 32'(idle_n[0]), 32'd2);
    chk("held_done7", 32'(done_n[0]), 32'd2);
    chk("held_idle3", 32'(idle_n[1]), 32'd4);
    chk("held_done3", 32'(done_n[1]), 32'd4);
    wait_idle("held");

    // abort in term 2 MUL_C
    done_rel = '{-1, -1};
    kick();
    while (cyc - sc[0] < 9) next_cycle();
    abort = 1'b1;
    next_cycle();
    abort = 1'b0;
    chk("abort_busy", 32'(busy_w), 32'd0);
    chk("abort_nodone", 32'(done_rel[0]), 32'hFFFF_FFFF);
    kick();
    wait_idle("after_abort");
    chk("abort_rerun7", 32'(done_rel[0]), 32'd26);
    chk("abort_rerun3", 32'(done_rel[1]), 32'd14);

    // reset pulse during term 0 EMIT
    kick();
    while (cyc - sc[0] < 4) next_cycle();
    rst = 1'b0;
    next_cycle();
    chk("rst_outputs", {ldx_w, ldt_w, it_w, ic_w, ce_w, sel_w, tv_w, busy_w, done_w}, 32'd0);
    start = 1'b1;
    repeat (3) next_cycle();
    chk("rst_low_start", 32'(busy_w), 32'd0);
    rst = 1'b1; start = 1'b0;
    next_cycle();

    // randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      start = ($urandom % 4) == 0;
      ack   = ($urandom % 3) != 0;
      abort = ($urandom % 60) == 0;
      rst   = ($urandom % 200) != 0;
      xbus  = 16'($urandom);
      next_cycle();
    end
    rst = 1'b1; start = 1'b0; abort = 1'b0; ack = 1'b1;
    wait_idle("final");
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
